sched_fetch_unit: RTL and testbench

Receiving end of the warp-schedule handshake: accepts one scheduled warp per cycle (uuid, wid, tmask, PC), issues the matching instruction-cache read tagged by warp id, and keeps the schedule metadata in a per-warp tag table until the response returns. It then pairs the instruction word with that metadata and presents it on a registered fetch output to decode. It sits between the warp scheduler and the decode stage, and is the slave side of the schedule interface.

---
 rtl/sched_fetch_pkg.sv | 31 +++
 rtl/sched_fetch_tag_table.sv | 42 ++++
 rtl/sched_fetch_unit.sv | 104 ++++++++++
 tb/tb_sched_fetch_unit.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sched_fetch_pkg.sv
// Shared sizing and payload types for the schedule/fetch handshake.
// Every width is derived from this package, so a new core configuration
// only has to edit the values below.
package sched_fetch_pkg;

  localparam int NUM_WARPS  = 8;
  localparam int THREAD_CNT = 4;
  localparam int XLEN       = 32;
  localparam int UUID_WIDTH = 16;

  // A single-warp core still needs a 1-bit warp id.
  localparam int NW_WIDTH = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

  typedef struct packed {
    logic [UUID_WIDTH-1:0] uuid;
    logic [NW_WIDTH-1:0]   wid;
    logic [THREAD_CNT-1:0] tmask;
    logic [XLEN-1:0]       PC;
  } sched_data_t;

  typedef struct packed {
    logic [UUID_WIDTH-1:0] uuid;
    logic [NW_WIDTH-1:0]   wid;
    logic [THREAD_CNT-1:0] tmask;
    logic [XLEN-1:0]       PC;
    logic [31:0]           instr;
  } fetch_data_t;

  localparam int SCHED_W = $bits(sched_data_t);

endpackage

// File: rtl/sched_fetch_tag_table.sv
// Per-warp tag table: one pending bit per warp plus the schedule payload
// captured at request time. One write port (request fire) and one
// read/clear port addressed by the returning response tag.
module sched_fetch_tag_table
  import sched_fetch_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [SCHED_W-1:0]   wr_data,
  input  logic                 clr_en,
  input  logic [NW_WIDTH-1:0]  rd_tag,
  output logic                 rd_pending,
  output logic [SCHED_W-1:0]   rd_data,
  output logic [NUM_WARPS-1:0] pending
);

  sched_data_t wr_entry;
  sched_data_t entries [NUM_WARPS];

  assign wr_entry = sched_data_t'(wr_data);

  // Pending bits: set on request fire, cleared when the response is consumed.
  // Set and clear never target the same warp because a pending warp cannot fire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      if (clr_en) pending[rd_tag] <= 1'b0;
      if (wr_en)  pending[wr_entry.wid] <= 1'b1;
    end
  end

  // Payload storage needs no reset; it is only read while its pending bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) entries[wr_entry.wid] <= wr_entry;
  end

  assign rd_pending = pending[rd_tag];
  assign rd_data    = entries[rd_tag];

endmodule

// File: rtl/sched_fetch_unit.sv
// Fetch front end: gates scheduled warps into icache requests, remembers
// their metadata per warp, and pairs each icache response with it on a
// registered output toward decode.
module sched_fetch_unit
  import sched_fetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sched_valid,
  input  logic [UUID_WIDTH-1:0] sched_uuid,
  input  logic [NW_WIDTH-1:0]   sched_wid,
  input  logic [THREAD_CNT-1:0] sched_tmask,
  input  logic [XLEN-1:0]       sched_PC,
  output logic                  sched_ready,
  output logic                  icache_req_valid,
  output logic [XLEN-3:0]       icache_req_addr,
  output logic [NW_WIDTH-1:0]   icache_req_tag,
  input  logic                  icache_req_ready,
  input  logic                  icache_rsp_valid,
  input  logic [31:0]           icache_rsp_data,
  input  logic [NW_WIDTH-1:0]   icache_rsp_tag,
  output logic                  icache_rsp_ready,
  output logic                  fetch_valid,
  output logic [UUID_WIDTH-1:0] fetch_uuid,
  output logic [NW_WIDTH-1:0]   fetch_wid,
  output logic [THREAD_CNT-1:0] fetch_tmask,
  output logic [XLEN-1:0]       fetch_PC,
  output logic [31:0]           fetch_instr,
  input  logic                  fetch_ready,
  output logic                  busy
);

  logic [NUM_WARPS-1:0] pending;
  logic                 rsp_pending;
  logic [SCHED_W-1:0]   rsp_entry_bits;
  sched_data_t          rsp_entry;
  sched_data_t          sched_data;
  fetch_data_t          fetch_q;
  logic                 sched_blocked;
  logic                 sched_fire;
  logic                 rsp_fire;
  logic                 rsp_hit;

  assign sched_data = '{uuid: sched_uuid, wid: sched_wid, tmask: sched_tmask, PC: sched_PC};

  // A warp with a request in flight must wait for its response before re-issuing.
  assign sched_blocked    = pending[sched_wid];
  assign icache_req_valid = sched_valid & ~sched_blocked;
  assign sched_ready      = icache_req_ready & ~sched_blocked;
  assign icache_req_addr  = sched_PC[XLEN-1:2];
  assign icache_req_tag   = sched_wid;
  assign sched_fire       = sched_valid & sched_ready;

  assign icache_rsp_ready = ~fetch_valid | fetch_ready;
  assign rsp_fire         = icache_rsp_valid & icache_rsp_ready;
  assign rsp_hit          = rsp_fire & rsp_pending;
  assign rsp_entry        = sched_data_t'(rsp_entry_bits);

  sched_fetch_tag_table u_tag_table (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (sched_fire),
    .wr_data    (SCHED_W'(sched_data)),
    .clr_en     (rsp_hit),
    .rd_tag     (icache_rsp_tag),
    .rd_pending (rsp_pending),
    .rd_data    (rsp_entry_bits),
    .pending    (pending)
  );

  // Output register: load on a matched response, otherwise drain on fetch_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_valid <= 1'b0;
      fetch_q     <= '0;
    end else if (rsp_hit) begin
      fetch_valid <= 1'b1;
      fetch_q     <= '{uuid:  rsp_entry.uuid,
                       wid:   icache_rsp_tag,
                       tmask: rsp_entry.tmask,
                       PC:    rsp_entry.PC,
                       instr: icache_rsp_data};
    end else if (fetch_ready) begin
      fetch_valid <= 1'b0;
    end
  end

  assign fetch_uuid  = fetch_q.uuid;
  assign fetch_wid   = fetch_q.wid;
  assign fetch_tmask = fetch_q.tmask;
  assign fetch_PC    = fetch_q.PC;
  assign fetch_instr = fetch_q.instr;

  assign busy = (|pending) | fetch_valid;

  // Flag responses that match no outstanding request; they are dropped.
  always @(posedge clk) begin
    if (!reset && rsp_fire) begin
      assert (rsp_pending)
        else $warning("stray icache response, tag %0d dropped", icache_rsp_tag);
    end
  end

endmodule

// File: tb/tb_sched_fetch_unit.sv
// Bench for sched_fetch_unit: directed scenarios plus random traffic, all
// checked every cycle against a per-warp transaction model.
module tb_sched_fetch_unit;
  import sched_fetch_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  sched_valid;
  logic [UUID_WIDTH-1:0] sched_uuid;
  logic [NW_WIDTH-1:0]   sched_wid;
  logic [THREAD_CNT-1:0] sched_tmask;
  logic [XLEN-1:0]       sched_PC;
  logic                  sched_ready;
  logic                  icache_req_valid;
  logic [XLEN-3:0]       icache_req_addr;
  logic [NW_WIDTH-1:0]   icache_req_tag;
  logic                  icache_req_ready;
  logic                  icache_rsp_valid;
  logic [31:0]           icache_rsp_data;
  logic [NW_WIDTH-1:0]   icache_rsp_tag;
  logic                  icache_rsp_ready;
  logic                  fetch_valid;
  logic [UUID_WIDTH-1:0] fetch_uuid;
  logic [NW_WIDTH-1:0]   fetch_wid;
  logic [THREAD_CNT-1:0] fetch_tmask;
  logic [XLEN-1:0]       fetch_PC;
  logic [31:0]           fetch_instr;
  logic                  fetch_ready;
  logic                  busy;

  int n_total = 0;
  int n_bad   = 0;

  // reference model: which warps are outstanding, what they carried, and the output slot
  bit          m_pend [NUM_WARPS];
  sched_data_t m_tab  [NUM_WARPS];
  bit          m_fv;
  fetch_data_t m_out;

  int          pq[$];
  int          ooo_order [3] = '{3, 0, 1};
  logic [31:0] ooo_pc    [4] = '{32'h0000_1000, 32'h0000_2000, 32'h0, 32'h0000_3000};
  logic [3:0]  ooo_tm    [4] = '{4'h1, 4'h3, 4'h0, 4'h7};
  bit          r_sv, r_rr, r_rv, r_fr;
  int          r_tag;

  always #5 clk = ~clk;

  sched_fetch_unit dut (
    .clk              (clk),
    .reset            (reset),
    .sched_valid      (sched_valid),
    .sched_uuid       (sched_uuid),
    .sched_wid        (sched_wid),
    .sched_tmask      (sched_tmask),
    .sched_PC         (sched_PC),
    .sched_ready      (sched_ready),
    .icache_req_valid (icache_req_valid),
    .icache_req_addr  (icache_req_addr),
    .icache_req_tag   (icache_req_tag),
    .icache_req_ready (icache_req_ready),
    .icache_rsp_valid (icache_rsp_valid),
    .icache_rsp_data  (icache_rsp_data),
    .icache_rsp_tag   (icache_rsp_tag),
    .icache_rsp_ready (icache_rsp_ready),
    .fetch_valid      (fetch_valid),
    .fetch_uuid       (fetch_uuid),
    .fetch_wid        (fetch_wid),
    .fetch_tmask      (fetch_tmask),
    .fetch_PC         (fetch_PC),
    .fetch_instr      (fetch_instr),
    .fetch_ready      (fetch_ready),
    .busy             (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < NUM_WARPS; w++) m_pend[w] = 1'b0;
    m_fv  = 1'b0;
    m_out = '0;
  endtask

  function automatic bit model_busy();
    bit b = m_fv;
    for (int w = 0; w < NUM_WARPS; w++) b |= m_pend[w];
    return b;
  endfunction

  task automatic drive(input bit sv, input int wid, input logic [UUID_WIDTH-1:0] uuid,
                       input logic [THREAD_CNT-1:0] tm, input logic [31:0] pc, input bit rr,
                       input bit rv, input int rtag, input logic [31:0] rdata, input bit fr);
    sched_valid      = sv;
    sched_wid        = NW_WIDTH'(wid);
    sched_uuid       = uuid;
    sched_tmask      = tm;
    sched_PC         = pc;
    icache_req_ready = rr;
    icache_rsp_valid = rv;
    icache_rsp_tag   = NW_WIDTH'(rtag);
    icache_rsp_data  = rdata;
    fetch_ready      = fr;
  endtask

  // Called just after a falling edge with inputs applied: check everything
  // against the model, advance the model, and return at the next falling edge.
  task automatic cycle();
    bit exp_sr, exp_rr, sfire, rfire;
    int t;
    #1;
    exp_sr = icache_req_ready && !m_pend[sched_wid];
    exp_rr = !m_fv || fetch_ready;
    check("sched_ready", sched_ready, exp_sr);
    check("req_valid", icache_req_valid, sched_valid && !m_pend[sched_wid]);
    if (sched_valid && !m_pend[sched_wid]) begin
      check("req_addr", icache_req_addr, sched_PC >> 2);
      check("req_tag", icache_req_tag, sched_wid);
    end
    check("rsp_ready", icache_rsp_ready, exp_rr);
    check("fetch_valid", fetch_valid, m_fv);
    check("fetch_uuid", fetch_uuid, m_out.uuid);
    check("fetch_wid", fetch_wid, m_out.wid);
    check("fetch_tmask", fetch_tmask, m_out.tmask);
    check("fetch_pc", fetch_PC, m_out.PC);
    check("fetch_instr", fetch_instr, m_out.instr);
    check("busy", busy, model_busy());

    sfire = sched_valid && exp_sr;
    rfire = icache_rsp_valid && exp_rr;
    t = int'(icache_rsp_tag);
    if (rfire && m_pend[t]) begin
      m_out = '{uuid: m_tab[t].uuid, wid: icache_rsp_tag, tmask: m_tab[t].tmask,
                PC: m_tab[t].PC, instr: icache_rsp_data};
      m_fv = 1'b1;
      m_pend[t] = 1'b0;
    end else if (fetch_ready) begin
      m_fv = 1'b0;
    end
    if (sfire) begin
      m_pend[sched_wid] = 1'b1;
      m_tab[sched_wid]  = '{uuid: sched_uuid, wid: sched_wid, tmask: sched_tmask, PC: sched_PC};
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 0, '0, '0, 32'h0, 1, 0, 0, 32'h0, 1);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_fetch_valid", fetch_valid, 0);
    check("rst_fetch_pc", fetch_PC, 0);
    check("rst_sched_ready", sched_ready, 1);
    reset = 1'b0;
    @(negedge clk);

    // single fetch
    drive(1, 2, 16'd5, 4'hF, 32'h8000_0010, 1, 0, 0, 32'h0, 1);
    #1;
    check("t1_req_addr", icache_req_addr, 30'h2000_0004);
    check("t1_req_valid", icache_req_valid, 1);
    cycle();
    drive(0, 0, '0, '0, 32'h0, 1, 1, 2, 32'h0000_0013, 1);
    cycle();
    check("t1_fetch_valid", fetch_valid, 1);
    check("t1_fetch_uuid", fetch_uuid, 5);
    check("t1_fetch_pc", fetch_PC, 32'h8000_0010);
    check("t1_fetch_tmask", fetch_tmask, 4'hF);
    check("t1_fetch_instr", fetch_instr, 32'h13);
    idle();
    cycle();

    // same-warp hazard
    drive(1, 1, 16'h11, 4'h3, 32'h0000_0100, 1, 0, 0, 32'h0, 1);
    cycle();
    drive(1, 1, 16'h12, 4'h5, 32'h0000_0200, 1, 0, 0, 32'h0, 1);
    repeat (3) begin
      #1 check("t2_stall", sched_ready, 0);
      cycle();
    end
    drive(1, 1, 16'h12, 4'h5, 32'h0000_0200, 1, 1, 1, 32'h0000_AAAA, 1);
    #1 check("t2_stall_rsp", sched_ready, 0);
    cycle();
    check("t2_first_uuid", fetch_uuid, 16'h11);
    drive(1, 1, 16'h12, 4'h5, 32'h0000_0200, 1, 0, 0, 32'h0, 1);
    #1 check("t2_accept", sched_ready, 1);
    cycle();
    drive(0, 0, '0, '0, 32'h0, 1, 1, 1, 32'h0000_BBBB, 1);
    cycle();
    check("t2_second_uuid", fetch_uuid, 16'h12);
    check("t2_second_pc", fetch_PC, 32'h0000_0200);
    idle();
    cycle();

    // out-of-order completion
    for (int w = 0; w < 4; w++) begin
      if (w != 2) begin
        drive(1, w, UUID_WIDTH'(16'h30 + w), ooo_tm[w], ooo_pc[w], 1, 0, 0, 32'h0, 1);
        cycle();
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, '0, '0, 32'h0, 1, 1, ooo_order[i], 32'hC000_0000 + i, 1);
      cycle();
      check("t3_wid", fetch_wid, ooo_order[i]);
      check("t3_pc", fetch_PC, ooo_pc[ooo_order[i]]);
      check("t3_tmask", fetch_tmask, ooo_tm[ooo_order[i]]);
    end
    idle();
    cycle();

    // backpressure
    drive(1, 4, 16'h44, 4'h9, 32'h0000_4000, 1, 0, 0, 32'h0, 1);
    cycle();
    drive(1, 5, 16'h55, 4'hA, 32'h0000_5000, 1, 1, 4, 32'h0000_4444, 0);
    cycle();
    drive(0, 0, '0, '0, 32'h0, 1, 1, 5, 32'h0000_5555, 0);
    repeat (5) begin
      #1;
      check("t4_rsp_blocked", icache_rsp_ready, 0);
      check("t4_hold_pc", fetch_PC, 32'h0000_4000);
      cycle();
    end
    fetch_ready = 1'b1;
    #1 check("t4_rsp_open", icache_rsp_ready, 1);
    cycle();
    check("t4_no_bubble", fetch_valid, 1);
    check("t4_next_pc", fetch_PC, 32'h0000_5000);
    idle();
    cycle();
    check("t4_drained", fetch_valid, 0);

    // stray response
    drive(0, 0, '0, '0, 32'h0, 1, 1, 6, 32'hDEAD_BEEF, 1);
    #1 check("t5_rsp_ready", icache_rsp_ready, 1);
    cycle();
    check("t5_no_fetch", fetch_valid, 0);
    check("t5_idle", busy, 0);

    // reset with warps in flight
    for (int w = 0; w < 3; w++) begin
      drive(1, w, UUID_WIDTH'(16'h60 + w), 4'h1, 32'h0000_6000 + 32'(w * 4), 1, 0, 0, 32'h0, 1);
      cycle();
    end
    idle();
    #2 reset = 1'b1;
    #1;
    check("t6_busy_now", busy, 0);
    check("t6_fetch_valid", fetch_valid, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int w = 0; w < 3; w++) begin
      drive(0, 0, '0, '0, 32'h0, 1, 1, w, 32'h0000_0F00 + w, 1);
      cycle();
      check("t6_dropped", fetch_valid, 0);
    end
    drive(1, 0, 16'h77, 4'hC, 32'h0000_7000, 1, 0, 0, 32'h0, 1);
    cycle();
    drive(0, 0, '0, '0, 32'h0, 1, 1, 0, 32'h0000_0099, 1);
    cycle();
    check("t6_new_valid", fetch_valid, 1);
    check("t6_new_uuid", fetch_uuid, 16'h77);
    check("t6_new_instr", fetch_instr, 32'h99);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      pq = {};
      for (int w = 0; w < NUM_WARPS; w++) if (m_pend[w]) pq.push_back(w);
      r_sv = ($urandom_range(0, 9) < 6);
      r_rr = ($urandom_range(0, 3) != 0);
      r_rv = ($urandom_range(0, 2) != 0);
      r_fr = ($urandom_range(0, 9) < 7);
      if (pq.size() > 0 && $urandom_range(0, 15) != 0)
        r_tag = pq[$urandom_range(0, pq.size() - 1)];
      else
        r_tag = $urandom_range(0, NUM_WARPS - 1);
      drive(r_sv, $urandom_range(0, NUM_WARPS - 1), UUID_WIDTH'($urandom), THREAD_CNT'($urandom),
            $urandom, r_rr, r_rv, r_tag, $urandom, r_fr);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
